// File: rtl/mod_counter_if.sv
// Control and status bundle for mod_counter: count controls in, count and decodes out.
// The master side drives the controls; the counter itself is the slave.
interface mod_counter_if #(
  parameter int N = 8,
  parameter int M = 1
);
  logic         en;
  logic         up;
  logic         sat;
  logic         load;
  logic [N-1:0] load_val;
  logic [M-1:0] inc;
  logic [N-1:0] q;
  logic         tc;
  logic         step;
  logic         at_max;
  logic         at_zero;

  modport master (
    output en, up, sat, load, load_val, inc,
    input  q, tc, step, at_max, at_zero
  );

  modport slave (
    input  en, up, sat, load, load_val, inc,
    output q, tc, step, at_max, at_zero
  );
endinterface

// File: rtl/mod_counter.sv
// Modulo-MOD up/down counter with synchronous load, programmable step, wrap/saturate
// mode, clock-enable prescaler and registered terminal-count / step pulses.
module mod_counter #(
  parameter int N   = 8,
  parameter int M   = 1,
  parameter int MOD = 256,
  parameter int PRE = 1
) (
  input  logic         clk,
  input  logic         reset,
  mod_counter_if.slave bus
);
  // One spare bit above the wider operand keeps q+s and q+MOD-s exact.
  localparam int W   = ((N > M) ? N : M) + 1;
  localparam int PCW = (PRE > 1) ? $clog2(PRE) : 1;

  localparam logic [W-1:0]   MOD_W   = W'(MOD);
  localparam logic [W-1:0]   MAX_W   = W'(MOD - 1);
  localparam logic [PCW-1:0] PC_LAST = PCW'(PRE - 1);

  logic [N-1:0]   q_reg, q_next, ld_next;
  logic           tc_reg, tc_next;
  logic           step_reg;
  logic [PCW-1:0] pc_reg, pc_next;
  logic           adv;
  logic [W-1:0]   q_w, inc_w, s_w, ld_w, sum_w;

  always_comb begin
    adv     = bus.en && (pc_reg == PC_LAST);
    q_w     = W'(q_reg);
    inc_w   = W'(bus.inc);
    s_w     = (inc_w > MAX_W) ? MAX_W : inc_w;
    ld_w    = W'(bus.load_val);
    ld_next = (ld_w > MAX_W) ? N'(MAX_W) : bus.load_val;
    sum_w   = q_w + s_w;
    pc_next = pc_reg;
    q_next  = q_reg;
    tc_next = 1'b0;

    if (bus.en) begin
      pc_next = adv ? '0 : pc_reg + PCW'(1);
    end

    if (adv) begin
      if (bus.up) begin
        if (sum_w <= MAX_W) begin
          q_next = N'(sum_w);
        end else begin
          tc_next = 1'b1;
          q_next  = bus.sat ? N'(MAX_W) : N'(sum_w - MOD_W);
        end
      end else begin
        if (s_w <= q_w) begin
          q_next = N'(q_w - s_w);
        end else begin
          tc_next = 1'b1;
          q_next  = bus.sat ? '0 : N'(q_w + MOD_W - s_w);
        end
      end
    end
  end

  // Load overrides any advance and restarts the prescale interval.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_reg    <= '0;
      tc_reg   <= 1'b0;
      step_reg <= 1'b0;
      pc_reg   <= '0;
    end else if (bus.load) begin
      q_reg    <= ld_next;
      tc_reg   <= 1'b0;
      step_reg <= 1'b0;
      pc_reg   <= '0;
    end else begin
      q_reg    <= q_next;
      tc_reg   <= tc_next;
      step_reg <= adv;
      pc_reg   <= pc_next;
    end
  end

  assign bus.q       = q_reg;
  assign bus.tc      = tc_reg;
  assign bus.step    = step_reg;
  assign bus.at_max  = (q_reg == N'(MOD - 1));
  assign bus.at_zero = (q_reg == '0);
endmodule

// File: tb/tb_mod_counter.sv
// Directed bench for mod_counter: three instances cover MOD=10/PRE=1, MOD=10/PRE=3
// and MOD=2^N with a step input wider than the count.
module tb_mod_counter;
  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mod_counter_if #(.N(4), .M(4)) ifa ();
  mod_counter_if #(.N(4), .M(4)) ifb ();
  mod_counter_if #(.N(4), .M(5)) ifc ();

  mod_counter #(.N(4), .M(4), .MOD(10), .PRE(1)) dut_a (.clk(clk), .reset(reset), .bus(ifa.slave));
  mod_counter #(.N(4), .M(4), .MOD(10), .PRE(3)) dut_b (.clk(clk), .reset(reset), .bus(ifb.slave));
  mod_counter #(.N(4), .M(5), .MOD(16), .PRE(1)) dut_c (.clk(clk), .reset(reset), .bus(ifc.slave));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    ifa.en = 1'b1; ifb.en = 1'b1; ifc.en = 1'b1;
    repeat (2) tick();
    checks++;
    if ({ifa.q, ifa.tc, ifa.step, ifa.at_zero} !== {4'd0, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_a: got q=%0d tc=%b step=%b zero=%b required q=0 tc=0 step=0 zero=1",
               ifa.q, ifa.tc, ifa.step, ifa.at_zero);
    end
    checks++;
    if ({ifb.q, ifb.tc, ifb.step, ifb.at_zero} !== {4'd0, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_b: got q=%0d tc=%b step=%b zero=%b required q=0 tc=0 step=0 zero=1",
               ifb.q, ifb.tc, ifb.step, ifb.at_zero);
    end
    checks++;
    if ({ifc.q, ifc.tc, ifc.step, ifc.at_zero} !== {4'd0, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_c: got q=%0d tc=%b step=%b zero=%b required q=0 tc=0 step=0 zero=1",
               ifc.q, ifc.tc, ifc.step, ifc.at_zero);
    end
    $display("reset held: a q=%0d b q=%0d c q=%0d", ifa.q, ifb.q, ifc.q);
    ifa.en = 1'b0; ifb.en = 1'b0; ifc.en = 1'b0;
    reset = 1'b1;
    tick();
  endtask

  task automatic test_wrap_up();
    logic [3:0] eq;
    logic       etc, emax;
    ifa.up = 1'b1; ifa.sat = 1'b0; ifa.inc = 4'd1; ifa.en = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      eq   = 4'(k % 10);
      etc  = (k == 10);
      emax = (eq == 4'd9);
      checks++;
      if ({ifa.q, ifa.tc, ifa.step, ifa.at_max} !== {eq, etc, 1'b1, emax}) begin
        errors++;
        $display("FAIL wrap_up[%0d]: got q=%0d tc=%b step=%b max=%b required q=%0d tc=%b step=1 max=%b",
                 k, ifa.q, ifa.tc, ifa.step, ifa.at_max, eq, etc, emax);
      end
      $display("wrap_up edge %0d: q=%0d tc=%b max=%b", k, ifa.q, ifa.tc, ifa.at_max);
    end
    ifa.en = 1'b0;
    tick();
  endtask

  task automatic test_wrap_down();
    int exp_q[5]  = '{9, 6, 3, 0, 7};
    int exp_tc[5] = '{1, 0, 0, 0, 1};
    ifa.load = 1'b1; ifa.load_val = 4'd2;
    tick();
    checks++;
    if ({ifa.q, ifa.tc, ifa.step} !== {4'd2, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL load_2: got q=%0d tc=%b step=%b required q=2 tc=0 step=0", ifa.q, ifa.tc, ifa.step);
    end
    ifa.load = 1'b0; ifa.up = 1'b0; ifa.sat = 1'b0; ifa.inc = 4'd3; ifa.en = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++;
      if ({ifa.q, ifa.tc} !== {4'(exp_q[k]), 1'(exp_tc[k])}) begin
        errors++;
        $display("FAIL wrap_down[%0d]: got q=%0d tc=%b required q=%0d tc=%0d",
                 k, ifa.q, ifa.tc, exp_q[k], exp_tc[k]);
      end
      $display("wrap_down edge %0d: q=%0d tc=%b", k, ifa.q, ifa.tc);
    end
    ifa.en = 1'b0;
    tick();
  endtask

  task automatic test_saturate();
    ifa.load = 1'b1; ifa.load_val = 4'd7;
    tick();
    ifa.load = 1'b0; ifa.sat = 1'b1; ifa.up = 1'b1; ifa.inc = 4'd4; ifa.en = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++;
      if ({ifa.q, ifa.tc} !== {4'd9, 1'b1}) begin
        errors++;
        $display("FAIL sat_up[%0d]: got q=%0d tc=%b required q=9 tc=1", k, ifa.q, ifa.tc);
      end
      $display("sat_up edge %0d: q=%0d tc=%b", k, ifa.q, ifa.tc);
    end
    ifa.up = 1'b0;
    tick();
    checks++;
    if ({ifa.q, ifa.tc, ifa.step} !== {4'd5, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL sat_turn_down: got q=%0d tc=%b step=%b required q=5 tc=0 step=1", ifa.q, ifa.tc, ifa.step);
    end
    // en stays high: load must win over the advance.
    ifa.load = 1'b1; ifa.load_val = 4'd2;
    tick();
    checks++;
    if ({ifa.q, ifa.tc, ifa.step} !== {4'd2, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL sat_load: got q=%0d tc=%b step=%b required q=2 tc=0 step=0", ifa.q, ifa.tc, ifa.step);
    end
    ifa.load = 1'b0;
    tick();
    checks++;
    if ({ifa.q, ifa.tc, ifa.at_zero} !== {4'd0, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL sat_down: got q=%0d tc=%b zero=%b required q=0 tc=1 zero=1", ifa.q, ifa.tc, ifa.at_zero);
    end
    ifa.inc = 4'd0;
    tick();
    checks++;
    if ({ifa.q, ifa.tc, ifa.step} !== {4'd0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL zero_step: got q=%0d tc=%b step=%b required q=0 tc=0 step=1", ifa.q, ifa.tc, ifa.step);
    end
    $display("saturate: final q=%0d tc=%b step=%b", ifa.q, ifa.tc, ifa.step);
    ifa.en = 1'b0; ifa.sat = 1'b0;
    tick();
  endtask

  task automatic test_prescale();
    int q_t[8]    = '{0, 0, 1, 1, 1, 1, 1, 2};
    int step_t[8] = '{0, 0, 1, 0, 0, 0, 0, 1};
    int en_t[8]   = '{1, 1, 1, 1, 0, 0, 1, 1};
    ifb.load = 1'b1; ifb.load_val = 4'd0;
    tick();
    ifb.load = 1'b0; ifb.up = 1'b1; ifb.sat = 1'b0; ifb.inc = 4'd1; ifb.en = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      tick();
      checks++;
      if ({ifb.q, ifb.step, ifb.tc} !== {4'(c / 3), (c % 3 == 0), 1'b0}) begin
        errors++;
        $display("FAIL prescale[%0d]: got q=%0d step=%b tc=%b required q=%0d step=%0d tc=0",
                 c, ifb.q, ifb.step, ifb.tc, c / 3, (c % 3 == 0));
      end
      $display("prescale edge %0d: q=%0d step=%b", c, ifb.q, ifb.step);
    end
    ifb.en = 1'b0; ifb.load = 1'b1;
    tick();
    ifb.load = 1'b0;
    for (int c = 0; c < 8; c++) begin
      ifb.en = 1'(en_t[c]);
      tick();
      checks++;
      if ({ifb.q, ifb.step} !== {4'(q_t[c]), 1'(step_t[c])}) begin
        errors++;
        $display("FAIL prescale_gap[%0d]: got q=%0d step=%b required q=%0d step=%0d",
                 c + 1, ifb.q, ifb.step, q_t[c], step_t[c]);
      end
      $display("prescale_gap edge %0d: en=%0d q=%0d step=%b", c + 1, en_t[c], ifb.q, ifb.step);
    end
    ifb.en = 1'b0;
    tick();
  endtask

  task automatic test_load_priority();
    int q_t[3]  = '{9, 9, 0};
    int tc_t[3] = '{0, 0, 1};
    ifb.load = 1'b1; ifb.load_val = 4'd0; ifb.en = 1'b0;
    tick();
    ifb.load = 1'b0; ifb.en = 1'b1; ifb.up = 1'b1; ifb.inc = 4'd1;
    tick();
    ifb.load = 1'b1; ifb.load_val = 4'd15;
    tick();
    checks++;
    if ({ifb.q, ifb.tc, ifb.step, ifb.at_max} !== {4'd9, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL load_clamp: got q=%0d tc=%b step=%b max=%b required q=9 tc=0 step=0 max=1",
               ifb.q, ifb.tc, ifb.step, ifb.at_max);
    end
    ifb.load = 1'b0;
    // A full PRE interval must elapse, proving the partial count was cleared.
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if ({ifb.q, ifb.tc, ifb.step} !== {4'(q_t[c]), 1'(tc_t[c]), 1'(tc_t[c])}) begin
        errors++;
        $display("FAIL load_pc_clear[%0d]: got q=%0d tc=%b step=%b required q=%0d tc=%0d step=%0d",
                 c + 1, ifb.q, ifb.tc, ifb.step, q_t[c], tc_t[c], tc_t[c]);
      end
      $display("after load edge %0d: q=%0d tc=%b step=%b", c + 1, ifb.q, ifb.tc, ifb.step);
    end
    ifb.en = 1'b0;
    tick();
  endtask

  task automatic test_async_reset();
    ifa.load = 1'b1; ifa.load_val = 4'd9; ifa.inc = 4'd3; ifa.up = 1'b1; ifa.sat = 1'b0;
    ifb.load = 1'b1; ifb.load_val = 4'd5; ifb.inc = 4'd1; ifb.up = 1'b1; ifb.sat = 1'b0;
    tick();
    ifa.load = 1'b0; ifb.load = 1'b0; ifa.en = 1'b1; ifb.en = 1'b1;
    tick();
    checks++;
    if ({ifa.q, ifa.tc, ifa.step, ifb.q, ifb.step} !== {4'd2, 1'b1, 1'b1, 4'd5, 1'b0}) begin
      errors++;
      $display("FAIL pre_reset: got a q=%0d tc=%b step=%b b q=%0d step=%b required a q=2 tc=1 step=1 b q=5 step=0",
               ifa.q, ifa.tc, ifa.step, ifb.q, ifb.step);
    end
    ifa.en = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({ifa.q, ifa.tc, ifa.step, ifb.q, ifb.at_zero} !== {4'd0, 1'b0, 1'b0, 4'd0, 1'b1}) begin
      errors++;
      $display("FAIL async_reset: got a q=%0d tc=%b step=%b b q=%0d zero=%b required all zero, zero=1",
               ifa.q, ifa.tc, ifa.step, ifb.q, ifb.at_zero);
    end
    $display("async reset: a q=%0d tc=%b step=%b b q=%0d", ifa.q, ifa.tc, ifa.step, ifb.q);
    tick();
    checks++;
    if ({ifb.q, ifb.step} !== {4'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset_hold: got q=%0d step=%b required q=0 step=0", ifb.q, ifb.step);
    end
    #3;
    reset = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      tick();
      checks++;
      if ({ifb.q, ifb.step} !== {4'(c / 3), (c == 3)}) begin
        errors++;
        $display("FAIL post_reset[%0d]: got q=%0d step=%b required q=%0d step=%0d",
                 c, ifb.q, ifb.step, c / 3, (c == 3));
      end
      $display("post reset edge %0d: q=%0d step=%b", c, ifb.q, ifb.step);
    end
    ifb.en = 1'b0;
    tick();
  endtask

  task automatic test_mod_pow2();
    ifc.load = 1'b1; ifc.load_val = 4'd14; ifc.sat = 1'b0;
    tick();
    ifc.load = 1'b0; ifc.up = 1'b1; ifc.inc = 5'd3; ifc.en = 1'b1;
    tick();
    checks++;
    if ({ifc.q, ifc.tc} !== {4'd1, 1'b1}) begin
      errors++;
      $display("FAIL pow2_up_wrap: got q=%0d tc=%b required q=1 tc=1", ifc.q, ifc.tc);
    end
    ifc.up = 1'b0;
    tick();
    checks++;
    if ({ifc.q, ifc.tc} !== {4'd14, 1'b1}) begin
      errors++;
      $display("FAIL pow2_down_wrap: got q=%0d tc=%b required q=14 tc=1", ifc.q, ifc.tc);
    end
    // inc=31 exceeds MOD-1 and must act as a step of 15.
    ifc.up = 1'b1; ifc.inc = 5'd31;
    tick();
    checks++;
    if ({ifc.q, ifc.tc} !== {4'd13, 1'b1}) begin
      errors++;
      $display("FAIL pow2_wide_step: got q=%0d tc=%b required q=13 tc=1", ifc.q, ifc.tc);
    end
    ifc.en = 1'b0; ifc.load = 1'b1; ifc.load_val = 4'd15;
    tick();
    checks++;
    if ({ifc.q, ifc.at_max} !== {4'd15, 1'b1}) begin
      errors++;
      $display("FAIL pow2_load_max: got q=%0d max=%b required q=15 max=1", ifc.q, ifc.at_max);
    end
    ifc.load = 1'b0; ifc.sat = 1'b1; ifc.en = 1'b1;
    tick();
    checks++;
    if ({ifc.q, ifc.tc} !== {4'd15, 1'b1}) begin
      errors++;
      $display("FAIL pow2_sat: got q=%0d tc=%b required q=15 tc=1", ifc.q, ifc.tc);
    end
    ifc.up = 1'b0; ifc.inc = 5'd1;
    tick();
    checks++;
    if ({ifc.q, ifc.tc} !== {4'd14, 1'b0}) begin
      errors++;
      $display("FAIL pow2_sat_down: got q=%0d tc=%b required q=14 tc=0", ifc.q, ifc.tc);
    end
    $display("mod 2^N: final q=%0d tc=%b", ifc.q, ifc.tc);
    ifc.en = 1'b0;
    tick();
  endtask

  initial begin
    ifa.en = 1'b0; ifa.up = 1'b1; ifa.sat = 1'b0; ifa.load = 1'b0; ifa.load_val = '0; ifa.inc = '0;
    ifb.en = 1'b0; ifb.up = 1'b1; ifb.sat = 1'b0; ifb.load = 1'b0; ifb.load_val = '0; ifb.inc = '0;
    ifc.en = 1'b0; ifc.up = 1'b1; ifc.sat = 1'b0; ifc.load = 1'b0; ifc.load_val = '0; ifc.inc = '0;
    test_reset();
    test_wrap_up();
    test_wrap_down();
    test_saturate();
    test_prescale();
    test_load_priority();
    test_async_reset();
    test_mod_pow2();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mod_counter.md
Name: mod_counter

Overview:
- Parametrised successor to the basic up-counter, used for scan-column sequencing, debounce timing and display-refresh division in the keypad scanner.
- Provides a modulo-MOD up/down counter with:
  - synchronous load
  - programmable step
  - wrap or saturate mode
  - built-in clock-enable prescaler
  - registered terminal-count pulse

Parameters:
N, 8, width of count register q
M, 1, width of step input inc
MOD, 256, count modulus; q ranges 0..MOD-1; legal range 2 <= MOD <= 2^N
PRE, 1, prescale ratio; count advances once per PRE enabled cycles; PRE >= 1

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
en  in  1  count enable; gates prescaler and counter
up  in  1  direction; 1 = increment, 0 = decrement
sat  in  1  mode; 1 = saturate at bounds, 0 = wrap modulo MOD
load  in  1  synchronous load strobe
load_val  in  N  value loaded when load=1
inc  in  M  step magnitude
q  out  N  current count (registered)
tc  out  1  registered one-cycle pulse: last advance wrapped or clamped
step  out  1  registered prescaler tick; high in cycles where an advance occurs
at_max  out  1  combinational decode, q == MOD-1
at_zero  out  1  combinational decode, q == 0

Behaviour:
- Reset: reset=0 asynchronously forces q=0, tc=0, step=0 and prescaler count pc=0. All stay at 0 while reset is held. Release is synchronous to the next clk edge. Reset mid-count discards partial prescale progress.
- Priority each clk edge: reset > load > advance > hold.
- Load:
  - q <= min(load_val, MOD-1).
  - pc <= 0, tc <= 0, step <= 0.
  - en, up and inc are ignored that cycle.
- Prescaler:
  - pc counts 0..PRE-1 while en=1 and load=0.
  - adv = en & (pc == PRE-1); on adv, pc <= 0.
  - en=0 holds pc (does not clear it).
  - PRE=1 gives adv = en every cycle; pc is then constant 0.
- step <= adv (registered), i.e. step is high the cycle after the advance edge, aligned with the new q.
- Step value: s = min(inc, MOD-1), zero-extended. Arithmetic is done in max(N,M)+1 bits; no intermediate overflow is permitted.
- Advance up (adv=1, up=1):
  - If q + s <= MOD-1: q <= q + s.
  - Else, wrap mode: q <= q + s - MOD.
  - Else, sat mode: q <= MOD-1.
- Advance down (adv=1, up=0):
  - If s <= q: q <= q - s.
  - Else, wrap mode: q <= q + MOD - s.
  - Else, sat mode: q <= 0.
- tc:
  - tc <= 1 iff adv=1 and the bound branch (wrap or clamp) was taken.
  - Saturate at the bound with s > 0 re-asserts tc on every advance (q unchanged).
  - s=0: q holds, tc=0, step still pulses.
- No advance: q holds, tc <= 0.
- Mode and direction inputs are sampled only on the advance edge. Changing them between advances has no other effect.
- MOD = 2^N is legal: wrap is natural overflow, and the comparisons still hold in the wide arithmetic.

Test Plan:
- N=4, MOD=10, PRE=1, inc=1, up=1, sat=0, en=1 from q=0: q runs 0..9 then 0. tc high exactly in the cycle q shows 0 after 9; at_max high while q=9.
- Same config, up=0, inc=3, load_val=2 loaded: next q values are 9, 6, 3, 0, 7. tc high with 9 and with 7 only.
- sat=1, up=1, inc=4, MOD=10, q=7: q->9 with tc=1; next advance q stays 9 with tc=1 again. Switch up=0: q->5 with tc=0.
- PRE=3, inc=1, en=1 for 9 cycles from q=0: q increments on cycles 3, 6, 9 only, with step pulses aligned. Drop en for 2 cycles after cycle 4: next increment delayed by exactly 2 cycles.
- load=1 with load_val=15 (MOD=10) concurrent with en=1: q=9, tc=0, pc cleared.
- Assert reset=0 asynchronously mid-prescale (pc=1, q=5), between clock edges: q=0, tc=0, step=0 immediately. After release, the first advance occurs PRE enabled cycles later.
